mul_cell_sequencer: RTL and testbench
=====================================

Name: mul_cell_sequencer

Overview:
Two-requester controller for the CPU's shared 3-partial-product multiplier cell (16x16 unsigned lo*lo, lo*hi, hi*lo; one clock-enabled register stage, async clear).
- Arbitrates between requesters and drives the cell's operands and enable.
- Runs one pass for a 32-bit low product (MUL) or two passes for the unsigned high word (MULXUU).
- Recombines partial products and returns the result with the requester ID.

Parameters:
PRIORITY_MODE, 0, 0 = round-robin between requesters; 1 = fixed priority, requester 0 wins.

Ports:
clk  in  1  system clock
reset_n  in  1  reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept strobe
req_op0  in  1  requester 0 op: 0=MUL (low 32), 1=MULXUU (high 32, unsigned)
req_op1  in  1  requester 1 op
req_a0, req_b0  in  32 each  requester 0 operands
req_a1, req_b1  in  32 each  requester 1 operands
rsp_valid  out  1  one-cycle result strobe
rsp_id  out  1  requester index of the result
rsp_data  out  32  result word
busy  out  1  high in any state other than IDLE
E_src1, E_src2  out  32 each  operands to the multiplier cell
M_en  out  1  multiplier cell register enable
M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3  in  32 each  cell partial products

Behaviour:
- Reset: one clock (clk); reset_n is asynchronous and active-low.
  - While reset_n is low: all outputs 0, state=IDLE, last_grant=1.
  - With last_grant=1, requester 0 wins the first contention.
- FSM states: IDLE, ISSUE1, CAP1, ISSUE2, CAP2, DONE.
- IDLE:
  - If any req_valid is set, grant one requester: req_ready[g]=1 for that cycle only, combinationally from valid and state.
  - Register a, b, op and id. Next state ISSUE1.
  - req_ready is 0 in every other state.
- Arbitration:
  - Round-robin: with both valid, grant ~last_grant; update last_grant on each grant.
  - Single valid: grant it.
  - PRIORITY_MODE=1: grant requester 0 whenever valid.
- ISSUE1: E_src1=a_q, E_src2=b_q, M_en=1. Next state CAP1.
- CAP1:
  - M_en=0, so the cell holds its outputs. Partial products are valid this cycle.
  - mid = p2 + p3 (33 bits).
  - part = p1 + (mid << 16) (50 bits, registered).
  - If op=MUL, next state DONE. Else next state ISSUE2.
- ISSUE2: E_src1={16'h0, a_q[31:16]}, E_src2={16'h0, b_q[31:16]}, M_en=1. Next state CAP2.
- CAP2: hh = p1. hi = hh + part[49:32], truncated to 32 bits. Next state DONE.
- DONE:
  - rsp_valid=1 and rsp_id=id_q.
  - rsp_data = part[31:0] for MUL, hi for MULXUU.
  - Next state IDLE.
  - No response backpressure; the requester must sample in this cycle.
- Operand outputs: E_src1, E_src2 are 0 outside ISSUE states. M_en is 1 only in ISSUE1/ISSUE2.
- Latency, counting the accept cycle as 0:
  - MUL: rsp_valid at cycle 3.
  - MULXUU: rsp_valid at cycle 5.
  - Throughput: one op per 4 cycles (MUL) or 6 cycles (MULXUU), because IDLE is re-entered for the next accept.
- Boundary cases:
  - Requests arriving while busy are ignored, not queued; the requester holds valid.
  - A request that drops req_valid before being granted is never served.
  - Reset mid-operation aborts silently: no rsp_valid, cell enable deasserted at once.
  - All arithmetic is unsigned. Overflow above bit 63 is impossible.

Decomposition:
- Shared package:
  - op encoding constants (OP_MUL=0, OP_MULXUU=1)
  - state enum
  - constants HALF_W=16, PART_W=50
- One natural sub-module: mul_rr_arbiter (2-way round-robin/fixed grant with last_grant register).
- FSM and recombination adder stay in the top.

Test Plan:
- MUL, requester 0: a=0x00010002, b=0x00030004 -> req_ready[0] at cycle 0; M_en at cycle 1 only; rsp_valid at cycle 3 with rsp_id=0, rsp_data=0x000A0008.
- MULXUU, requester 1: a=b=0xFFFFFFFF -> two M_en pulses (cycles 1 and 3); second pass E_src1=E_src2=0x0000FFFF; rsp_valid at cycle 5 with rsp_id=1, rsp_data=0xFFFFFFFE.
- MULXUU: a=0x00010002, b=0x00030004 -> rsp_data=0x00000003. MUL: a=0x80000000, b=2 -> rsp_data=0.
- Both valid continuously after reset, round-robin -> grants alternate 0,1,0,1; each grant only in IDLE; rsp_id matches grant order.
- PRIORITY_MODE=1, both valid continuously -> requester 0 granted every time; requester 1 starves.
- reset_n low at ISSUE2 -> all outputs 0 at once; no rsp_valid; after release, a MUL with a=3, b=5 gives rsp_data=15 with the 3-cycle latency.

Source files
------------

// File: rtl/mul_cell_sequencer_pkg.sv
// Shared encodings, widths and the partial-product recombination helper
// for the multiplier-cell sequencer.
package mul_cell_sequencer_pkg;

    localparam int DATA_W = 32;
    localparam int HALF_W = 16;
    localparam int PART_W = 50;

    localparam logic OP_MUL    = 1'b0;
    localparam logic OP_MULXUU = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE1,
        ST_CAP1,
        ST_ISSUE2,
        ST_CAP2,
        ST_DONE
    } state_e;

    // lo*lo + ((lo*hi + hi*lo) << 16); the cross sum needs 33 bits before the shift.
    function automatic logic [PART_W-1:0] part_sum(
        input logic [DATA_W-1:0] p1,
        input logic [DATA_W-1:0] p2,
        input logic [DATA_W-1:0] p3
    );
        logic [DATA_W:0] mid;
        mid = {1'b0, p2} + {1'b0, p3};
        return {{(PART_W-DATA_W){1'b0}}, p1}
             + ({{(PART_W-DATA_W-1){1'b0}}, mid} << HALF_W);
    endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Two-way grant logic: round-robin on last_grant, or fixed priority to
// requester 0. Grants are combinational; last_grant updates on each grant.
module mul_rr_arbiter
    import mul_cell_sequencer_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [1:0] req_valid_i,
    output logic [1:0] grant_o,
    output logic       grant_id_o
);

    logic       last_grant_q;
    logic [1:0] grant_d;

    always_comb begin
        grant_d = 2'b00;
        if (en_i) begin
            if (PRIORITY_MODE != 0) begin
                if (req_valid_i[0]) begin
                    grant_d = 2'b01;
                end else if (req_valid_i[1]) begin
                    grant_d = 2'b10;
                end
            end else begin
                case (req_valid_i)
                    2'b01:   grant_d = 2'b01;
                    2'b10:   grant_d = 2'b10;
                    2'b11:   grant_d = last_grant_q ? 2'b01 : 2'b10;
                    default: grant_d = 2'b00;
                endcase
            end
        end
    end

    // Reset value 1 makes requester 0 win the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= 1'b1;
        end else if (grant_d != 2'b00) begin
            last_grant_q <= grant_d[1];
        end
    end

    assign grant_o    = grant_d;
    assign grant_id_o = grant_d[1];

endmodule

// File: rtl/mul_cell_sequencer.sv
// Sequences the shared 3-partial-product multiplier cell for two requesters:
// one pass for MUL (low word), two passes for MULXUU (unsigned high word).
module mul_cell_sequencer
    import mul_cell_sequencer_pkg::*;
#(
    parameter int PRIORITY_MODE = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic              req_op0,
    input  logic              req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic [DATA_W-1:0] E_src1,
    output logic [DATA_W-1:0] E_src2,
    output logic              M_en,
    input  logic [DATA_W-1:0] M_mul_cell_p1,
    input  logic [DATA_W-1:0] M_mul_cell_p2,
    input  logic [DATA_W-1:0] M_mul_cell_p3
);

    localparam int PART_HI_W = PART_W - DATA_W;

    state_e               state_q;
    logic [HALF_W-1:0]    a_hi_q;
    logic [HALF_W-1:0]    b_hi_q;
    logic                 op_q;
    logic                 id_q;
    logic [PART_HI_W-1:0] part_hi_q;
    logic                 rsp_valid_q;
    logic                 rsp_id_q;
    logic [DATA_W-1:0]    rsp_data_q;
    logic [DATA_W-1:0]    e_src1_q;
    logic [DATA_W-1:0]    e_src2_q;
    logic                 m_en_q;

    logic [1:0]           grant;
    logic                 grant_id;
    logic                 arb_en;
    logic [DATA_W-1:0]    sel_a_d;
    logic [DATA_W-1:0]    sel_b_d;
    logic                 sel_op_d;
    logic [PART_W-1:0]    part_d;
    logic [DATA_W-1:0]    hi_d;

    // Gating with reset_n keeps req_ready low while reset is held.
    assign arb_en = (state_q == ST_IDLE) && reset_n;

    mul_rr_arbiter #(
        .PRIORITY_MODE(PRIORITY_MODE)
    ) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (arb_en),
        .req_valid_i(req_valid),
        .grant_o    (grant),
        .grant_id_o (grant_id)
    );

    assign sel_a_d  = grant_id ? req_a1  : req_a0;
    assign sel_b_d  = grant_id ? req_b1  : req_b0;
    assign sel_op_d = grant_id ? req_op1 : req_op0;

    assign part_d = part_sum(M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3);
    // In CAP2 the cell's lo*lo output is a_hi*b_hi.
    assign hi_d   = M_mul_cell_p1 + {{(2*DATA_W-PART_W){1'b0}}, part_hi_q};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            a_hi_q      <= '0;
            b_hi_q      <= '0;
            op_q        <= OP_MUL;
            id_q        <= 1'b0;
            part_hi_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            e_src1_q    <= '0;
            e_src2_q    <= '0;
            m_en_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        state_q  <= ST_ISSUE1;
                        a_hi_q   <= sel_a_d[DATA_W-1:HALF_W];
                        b_hi_q   <= sel_b_d[DATA_W-1:HALF_W];
                        op_q     <= sel_op_d;
                        id_q     <= grant_id;
                        e_src1_q <= sel_a_d;
                        e_src2_q <= sel_b_d;
                        m_en_q   <= 1'b1;
                    end
                end
                ST_ISSUE1: begin
                    state_q  <= ST_CAP1;
                    e_src1_q <= '0;
                    e_src2_q <= '0;
                    m_en_q   <= 1'b0;
                end
                ST_CAP1: begin
                    part_hi_q <= part_d[PART_W-1:DATA_W];
                    if (op_q == OP_MUL) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        rsp_data_q  <= part_d[DATA_W-1:0];
                    end else begin
                        state_q  <= ST_ISSUE2;
                        e_src1_q <= {{HALF_W{1'b0}}, a_hi_q};
                        e_src2_q <= {{HALF_W{1'b0}}, b_hi_q};
                        m_en_q   <= 1'b1;
                    end
                end
                ST_ISSUE2: begin
                    state_q  <= ST_CAP2;
                    e_src1_q <= '0;
                    e_src2_q <= '0;
                    m_en_q   <= 1'b0;
                end
                ST_CAP2: begin
                    state_q     <= ST_DONE;
                    rsp_valid_q <= 1'b1;
                    rsp_id_q    <= id_q;
                    rsp_data_q  <= hi_d;
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_id_q    <= 1'b0;
                    rsp_data_q  <= '0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign E_src1    = e_src1_q;
    assign E_src2    = e_src2_q;
    assign M_en      = m_en_q;

endmodule

// File: tb/tb_mul_cell_sequencer.sv
// Bench for mul_cell_sequencer: round-robin and fixed-priority instances,
// each with its own behavioural multiplier cell; scoreboard on responses.
module tb_mul_cell_sequencer;

    typedef struct packed {
        logic        id;
        logic        op;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  vld, vld_p;
    logic        op0, op1;
    logic [31:0] a0, b0, a1, b1;

    logic [1:0]  ready, ready_p;
    logic        rsp_valid, rsp_valid_p;
    logic        rsp_id, rsp_id_p;
    logic [31:0] rsp_data, rsp_data_p;
    logic        busy, busy_p;
    logic [31:0] e1, e2, e1_p, e2_p;
    logic        men, men_p;
    logic [31:0] p1, p2, p3, p1_p, p2_p, p3_p;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb_q[$];
    int   acc_q[$];
    exp_t mon_e;
    int   mon_t0;

    mul_cell_sequencer #(.PRIORITY_MODE(0)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(vld), .req_ready(ready),
        .req_op0(op0), .req_op1(op1), .req_a0(a0), .req_b0(b0),
        .req_a1(a1), .req_b1(b1), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .busy(busy), .E_src1(e1), .E_src2(e2), .M_en(men),
        .M_mul_cell_p1(p1), .M_mul_cell_p2(p2), .M_mul_cell_p3(p3)
    );

    mul_cell_sequencer #(.PRIORITY_MODE(1)) dut_p (
        .clk(clk), .reset_n(reset_n), .req_valid(vld_p), .req_ready(ready_p),
        .req_op0(op0), .req_op1(op1), .req_a0(a0), .req_b0(b0),
        .req_a1(a1), .req_b1(b1), .rsp_valid(rsp_valid_p), .rsp_id(rsp_id_p),
        .rsp_data(rsp_data_p), .busy(busy_p), .E_src1(e1_p), .E_src2(e2_p), .M_en(men_p),
        .M_mul_cell_p1(p1_p), .M_mul_cell_p2(p2_p), .M_mul_cell_p3(p3_p)
    );

    function automatic logic [31:0] mul16(input logic [15:0] x, input logic [15:0] y);
        return {16'h0, x} * {16'h0, y};
    endfunction

    function automatic logic [31:0] expect_data(input logic op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] full;
        full = {32'h0, a} * {32'h0, b};
        return op ? full[63:32] : full[31:0];
    endfunction

    // Behavioural multiplier cells: one enabled register stage, async clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1 <= '0; p2 <= '0; p3 <= '0;
        end else if (men) begin
            p1 <= mul16(e1[15:0],  e2[15:0]);
            p2 <= mul16(e1[15:0],  e2[31:16]);
            p3 <= mul16(e1[31:16], e2[15:0]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p1_p <= '0; p2_p <= '0; p3_p <= '0;
        end else if (men_p) begin
            p1_p <= mul16(e1_p[15:0],  e2_p[15:0]);
            p2_p <= mul16(e1_p[15:0],  e2_p[31:16]);
            p3_p <= mul16(e1_p[31:16], e2_p[15:0]);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: accept cycles recorded from req_ready, responses popped in order.
    always @(negedge clk) begin
        if (reset_n && ready != 2'b00) acc_q.push_back(cyc);
        if (rsp_valid) begin
            n_tests++;
            if (sb_q.size() == 0 || acc_q.size() == 0) begin
                n_fail++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h, required no response", rsp_id, rsp_data);
            end else begin
                mon_e  = sb_q.pop_front();
                mon_t0 = acc_q.pop_front();
                if (rsp_id !== mon_e.id || rsp_data !== mon_e.data || (cyc - mon_t0) != (mon_e.op ? 5 : 3)) begin
                    n_fail++;
                    $display("FAIL rsp_check: got id=%0d data=%h lat=%0d, required id=%0d data=%h lat=%0d",
                             rsp_id, rsp_data, cyc - mon_t0, mon_e.id, mon_e.data, mon_e.op ? 5 : 3);
                end else begin
                    $display("[TB] rsp id=%0d data=%h lat=%0d ok", rsp_id, rsp_data, cyc - mon_t0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish within 200000 time units");
        $fatal(1);
    end

    task automatic do_reset();
        reset_n = 1'b0;
        vld     = 2'b00;
        vld_p   = 2'b00;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        sb_q.delete();
        acc_q.delete();
    endtask

    task automatic run_op(input logic id, input logic op, input logic [31:0] a, input logic [31:0] b);
        int   lat;
        exp_t e;
        lat = op ? 5 : 3;
        @(posedge clk); #1;
        if (id == 1'b0) begin a0 = a; b0 = b; op0 = op; end
        else            begin a1 = a; b1 = b; op1 = op; end
        vld[id]   = 1'b1;
        e.id = id; e.op = op; e.data = expect_data(op, a, b);
        sb_q.push_back(e);
        $display("[TB] issue id=%0d op=%0d a=%h b=%h", id, op, a, b);
        @(negedge clk);
        n_tests++;
        if (ready !== (2'b01 << id)) begin
            n_fail++;
            $display("FAIL accept_ready: got %b, required %b", ready, 2'b01 << id);
        end
        @(posedge clk); #1 vld = 2'b00;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            n_tests++;
            if (men !== ((k == 1) || (op && k == 3))) begin
                n_fail++;
                $display("FAIL m_en_cycle%0d: got %b, required %b", k, men, (k == 1) || (op && k == 3));
            end
            if (k == 1) begin
                n_tests++;
                if (e1 !== a || e2 !== b) begin
                    n_fail++;
                    $display("FAIL pass1_operands: got %h/%h, required %h/%h", e1, e2, a, b);
                end
            end
            if (op && k == 3) begin
                n_tests++;
                if (e1 !== {16'h0, a[31:16]} || e2 !== {16'h0, b[31:16]}) begin
                    n_fail++;
                    $display("FAIL pass2_operands: got %h/%h, required %h/%h",
                             e1, e2, {16'h0, a[31:16]}, {16'h0, b[31:16]});
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        vld     = 2'b11;
        vld_p   = 2'b11;
        @(negedge clk);
        n_tests++;
        if (ready !== 2'b00 || ready_p !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b/%b, required 00/00", ready, ready_p);
        end
        n_tests++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || men !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got rsp_valid=%b busy=%b m_en=%b, required 0 0 0", rsp_valid, busy, men);
        end
        n_tests++;
        if (e1 !== 32'h0 || e2 !== 32'h0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data: got e1=%h e2=%h data=%h id=%b, required zeros", e1, e2, rsp_data, rsp_id);
        end
        do_reset();
    endtask

    task automatic test_mul();
        run_op(1'b0, 1'b0, 32'h0001_0002, 32'h0003_0004);
    endtask

    task automatic test_mulxuu();
        run_op(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(1'b0, 1'b1, 32'h0001_0002, 32'h0003_0004);
    endtask

    task automatic test_boundary();
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h0000_0002);
        run_op(1'b0, 1'b1, 32'h0000_0000, 32'hFFFF_FFFF);
        run_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000);
    endtask

    task automatic test_back_to_back();
        int   grants;
        int   last_c;
        exp_t e;
        do_reset();
        a0 = 32'h1234_5678; b0 = 32'h0000_0010; op0 = 1'b0;
        a1 = 32'h0000_FFFF; b1 = 32'h0001_0001; op1 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            e.id = i[0]; e.op = 1'b0;
            e.data = i[0] ? expect_data(1'b0, a1, b1) : expect_data(1'b0, a0, b0);
            sb_q.push_back(e);
        end
        @(posedge clk); #1 vld = 2'b11;
        grants = 0;
        last_c = 0;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            @(negedge clk);
            if (ready != 2'b00) begin
                n_tests++;
                if (ready !== (grants[0] ? 2'b10 : 2'b01) || busy !== 1'b0 || (grants > 0 && c - last_c != 4)) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: got ready=%b busy=%b gap=%0d, required ready=%b busy=0 gap=4",
                             grants, ready, busy, c - last_c, grants[0] ? 2'b10 : 2'b01);
                end
                $display("[TB] rr grant %0d to requester %0d", grants, ready[1]);
                grants++;
                last_c = c;
            end
        end
        n_tests++;
        if (grants < 4) begin
            n_fail++;
            $display("FAIL rr_timeout: got %0d grants, required 4", grants);
        end
        @(posedge clk); #1 vld = 2'b00;
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(negedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL rr_drain: got %0d pending, required 0", sb_q.size());
        end
    endtask

    task automatic test_priority();
        int grants;
        int rsps;
        do_reset();
        a0 = 32'h0000_0007; b0 = 32'h0000_0009; op0 = 1'b0;
        a1 = 32'h0000_0011; b1 = 32'h0000_0013; op1 = 1'b0;
        @(posedge clk); #1 vld_p = 2'b11;
        grants = 0;
        rsps   = 0;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            @(negedge clk);
            if (ready_p != 2'b00) begin
                n_tests++;
                if (ready_p !== 2'b01) begin
                    n_fail++;
                    $display("FAIL prio_grant%0d: got %b, required 01", grants, ready_p);
                end
                $display("[TB] prio grant %0d to requester %0d", grants, ready_p[1]);
                grants++;
            end
            if (rsp_valid_p) begin
                n_tests++;
                rsps++;
                if (rsp_id_p !== 1'b0 || rsp_data_p !== 32'd63) begin
                    n_fail++;
                    $display("FAIL prio_rsp: got id=%0d data=%h, required id=0 data=%h", rsp_id_p, rsp_data_p, 32'd63);
                end
            end
        end
        n_tests++;
        if (grants < 4 || rsps < 3) begin
            n_fail++;
            $display("FAIL prio_timeout: got %0d grants %0d rsps, required 4 and 3", grants, rsps);
        end
        @(posedge clk); #1 vld_p = 2'b00;
        repeat (8) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        do_reset();
        a0 = 32'hFFFF_FFFF; b0 = 32'hFFFF_FFFF; op0 = 1'b1;
        @(posedge clk); #1 vld = 2'b01;
        @(negedge clk);
        n_tests++;
        if (ready !== 2'b01) begin
            n_fail++;
            $display("FAIL abort_accept: got %b, required 01", ready);
        end
        @(posedge clk); #1 vld = 2'b00;
        repeat (3) @(negedge clk);
        n_tests++;
        if (men !== 1'b1 || e1 !== 32'h0000_FFFF) begin
            n_fail++;
            $display("FAIL abort_issue2: got m_en=%b e1=%h, required 1 and 0000ffff", men, e1);
        end
        reset_n = 1'b0;
        #1;
        n_tests++;
        if (men !== 1'b0 || e1 !== 32'h0 || e2 !== 32'h0 || busy !== 1'b0 || rsp_valid !== 1'b0 || ready !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_outputs: got m_en=%b e1=%h e2=%h busy=%b rsp=%b ready=%b, required all zero",
                     men, e1, e2, busy, rsp_valid, ready);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_rsp: got rsp_valid=%b, required 0", rsp_valid);
            end
        end
        @(posedge clk); #1 reset_n = 1'b1;
        sb_q.delete();
        acc_q.delete();
        run_op(1'b0, 1'b0, 32'd3, 32'd5);
        repeat (2) @(posedge clk);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: got %0d pending, required 0", sb_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        vld = 2'b00; vld_p = 2'b00;
        op0 = 1'b0; op1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_mul();
        test_mulxuu();
        test_boundary();
        test_back_to_back();
        test_priority();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
